// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave framing RAM commands; MOSI in, MISO out.
// Define SPI_PARITY_EN to add a trailing even-parity bit on both directions.
module spi_slave_param #(
  parameter int PAY_W      = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               MOSI,
  input  logic [PAY_W-1:0]   tx_data,
  input  logic               tx_valid,
  output logic [PAY_W+1:0]   rx_data,
  output logic               rx_valid,
  output logic               MISO,
  output logic               busy,
  output logic               cmd_err
);
  localparam int FRAME_W = PAY_W + 2;
`ifdef SPI_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int RX_W = FRAME_W + PAR;
  localparam int TX_W = PAY_W + PAR;
  localparam int CW   = $clog2(RX_W + 1);

  typedef enum logic [2:0] {IDLE, RECV, WAIT_TX, SEND, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RX_W-2:0]    sh_q, sh_d;
  logic [RX_W-1:0]    sh_full;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d, frame;
  logic [TX_W-1:0]    tx_q, tx_d, tx_load;
  logic [7:0]         to_q, to_d;
  logic               rx_valid_q, rx_valid_d, miso_q, miso_d;
  logic               cmd_err_q, cmd_err_d, armed_q, armed_d, par_ok;

  // sh_q holds the bits already received; the bit on MOSI completes the frame
  assign sh_full = {sh_q, MOSI};
`ifdef SPI_PARITY_EN
  assign frame   = sh_full[RX_W-1:1];
  assign par_ok  = ~^sh_full;
  assign tx_load = {tx_data, ^tx_data};
`else
  assign frame   = sh_full;
  assign par_ok  = 1'b1;
  assign tx_load = tx_data;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    miso_d     = miso_q;
    armed_d    = armed_q;
    to_d       = to_q;
    tx_d       = tx_q;
    if (state_q != IDLE && SS_n) begin
      state_d = IDLE;
      cnt_d   = '0;
      to_d    = '0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!SS_n) begin
          state_d = RECV;
          cnt_d   = '0;
        end
        RECV: begin
          sh_d  = sh_full[RX_W-2:0];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(RX_W - 1)) begin
            state_d = DONE;
            if (!par_ok || (frame[FRAME_W-1 -: 2] == 2'b11 && !armed_q)) cmd_err_d = 1'b1;
            else begin
              rx_data_d  = frame;
              rx_valid_d = 1'b1;
              armed_d    = frame[FRAME_W-1 -: 2] == 2'b10 ? 1'b1 :
                           frame[FRAME_W-1 -: 2] == 2'b11 ? 1'b0 : armed_q;
              if (frame[FRAME_W-1 -: 2] == 2'b11) begin
                state_d = WAIT_TX;
                to_d    = '0;
              end
            end
          end
        end
        WAIT_TX: begin
          if (tx_valid) begin
            miso_d  = tx_load[TX_W-1];
            tx_d    = tx_load << 1;
            cnt_d   = CW'(1);
            state_d = SEND;
          end else if (to_q == 8'(TX_TIMEOUT - 1)) begin
            cmd_err_d = 1'b1;
            miso_d    = 1'b0;
            state_d   = DONE;
          end else to_d = to_q + 8'd1;
        end
        SEND: begin
          if (cnt_q == CW'(TX_W)) begin
            miso_d  = 1'b0;
            state_d = DONE;
          end else begin
            miso_d = tx_q[TX_W-1];
            tx_d   = tx_q << 1;
            cnt_d  = cnt_q + CW'(1);
          end
        end
        DONE:    miso_d  = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
      armed_q    <= 1'b0;
      to_q       <= '0;
      tx_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      cmd_err_q  <= cmd_err_d;
      armed_q    <= armed_d;
      to_q       <= to_d;
      tx_q       <= tx_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign MISO     = miso_q;
  assign cmd_err  = cmd_err_q;
  assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: randomized frames checked against a transaction-level model of the slave.
module tb_spi_slave_param;
  localparam int PAY_W = 8;
  localparam int TO    = 16;
`ifdef SPI_PARITY_EN
  localparam int FW  = 11;
  localparam int TXW = 9;
`else
  localparam int FW  = 10;
  localparam int TXW = 8;
`endif

  logic clk = 0, rst = 1, SS_n = 1, MOSI = 0, tx_valid = 0;
  logic [PAY_W-1:0] tx_data = '0;
  logic [9:0] rx_data;
  logic rx_valid, MISO, busy, cmd_err;
  int checks = 0, errors = 0;
  bit armed_m = 0, flip_par = 0;
  logic [9:0] rx_m = '0;

  always #5 clk = ~clk;

  spi_slave_param #(.PAY_W(PAY_W), .TX_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .tx_data(tx_data), .tx_valid(tx_valid),
    .rx_data(rx_data), .rx_valid(rx_valid), .MISO(MISO), .busy(busy), .cmd_err(cmd_err));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // n = bits shifted before SS_n rises (n < FW aborts), wt = idle WAIT_TX cycles before tx_valid
  task automatic do_txn(input logic [9:0] f, input int n, input int wt, input logic [7:0] d);
    logic [FW-1:0] fb;
    logic [TXW-1:0] txb;
    bit err, ok, rd;
`ifdef SPI_PARITY_EN
    fb  = {f, ^f ^ flip_par};
    txb = {d, ^d};
`else
    fb  = f;
    txb = d;
`endif
    SS_n = 0;
    tick;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_start: got %b want 1", busy); end
    for (int i = 0; i < n; i++) begin
      MOSI = fb[FW-1-i];
      tx_valid = 1'($urandom);
      tick;
      if (i < FW - 1) begin
        checks++;
        if ({rx_valid, cmd_err, MISO} !== 3'b000) begin
          errors++; $display("FAIL mid_frame bit %0d: valid/err/miso got %b want 000", i, {rx_valid, cmd_err, MISO});
        end
      end
    end
    tx_valid = 0;
    if (n < FW) begin
      SS_n = 1;
      tick;
      checks++;
      if ({busy, rx_valid, cmd_err} !== 3'b000 || rx_data !== rx_m) begin
        errors++; $display("FAIL abort: busy/valid/err %b data %h want 000 data %h", {busy, rx_valid, cmd_err}, rx_data, rx_m);
      end
      MOSI = 0;
      return;
    end
    err = flip_par || (f[9:8] == 2'b11 && !armed_m);
    ok  = !err;
    rd  = ok && f[9:8] == 2'b11;
    if (ok) rx_m = f;
    if (ok && f[9:8] == 2'b10) armed_m = 1;
    if (rd) armed_m = 0;
    checks++;
    if (rx_valid !== ok || cmd_err !== err || rx_data !== rx_m) begin
      errors++; $display("FAIL frame_end %h: valid %b err %b data %h want valid %b err %b data %h",
                         f, rx_valid, cmd_err, rx_data, ok, err, rx_m);
    end
    if (rd) begin
      for (int k = 1; k <= wt && k <= TO; k++) begin
        tick;
        checks++;
        if (rx_valid !== 1'b0 || MISO !== 1'b0 || cmd_err !== (k == TO) || busy !== 1'b1) begin
          errors++; $display("FAIL wait_tx cycle %0d: valid/miso/err/busy got %b want 00%b1", k,
                             {rx_valid, MISO, cmd_err, busy}, k == TO);
        end
      end
      if (wt < TO) begin
        tx_data = d;
        tx_valid = 1;
        tick;
        tx_valid = 0;
        tx_data = 8'($urandom);
        for (int i = 0; i < TXW; i++) begin
          MOSI = 1'($urandom);
          checks++;
          if (MISO !== txb[TXW-1-i]) begin
            errors++; $display("FAIL miso bit %0d of %h: got %b want %b", i, d, MISO, txb[TXW-1-i]);
          end
          tick;
        end
      end else tick;
      checks++;
      if ({MISO, cmd_err, busy} !== 3'b001) begin
        errors++; $display("FAIL after_read: miso/err/busy got %b want 001", {MISO, cmd_err, busy});
      end
    end else begin
      tick;
      checks++;
      if ({rx_valid, cmd_err, MISO, busy} !== 4'b0001) begin
        errors++; $display("FAIL after_frame: valid/err/miso/busy got %b want 0001", {rx_valid, cmd_err, MISO, busy});
      end
    end
    MOSI = 1'($urandom);
    tick;
    SS_n = 1;
    tick;
    checks++;
    if ({busy, MISO, rx_valid, cmd_err} !== 4'b0000) begin
      errors++; $display("FAIL end_frame: busy/miso/valid/err got %b want 0000", {busy, MISO, rx_valid, cmd_err});
    end
    MOSI = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    SS_n = 1;
    tick;
    tick;
    rst = 0;
    armed_m = 0;
    rx_m = '0;
    checks++;
    if ({rx_data, rx_valid, MISO, busy, cmd_err} !== 14'b0) begin
      errors++; $display("FAIL reset: data %h valid/miso/busy/err %b want all 0", rx_data, {rx_valid, MISO, busy, cmd_err});
    end
  endtask

  task automatic test_write_addr;
    do_txn(10'h0A5, FW, 1, 8'h00);
    for (int i = 0; i < 4; i++) do_txn({2'($urandom_range(0, 2)), 8'($urandom)}, FW, 1, 8'h00);
  endtask

  task automatic test_read_unarmed;
    test_reset();
    do_txn(10'h300, FW, 1, 8'h00);
  endtask

  task automatic test_read;
    do_txn({2'b10, 8'h0F}, FW, 1, 8'h00);
    do_txn({2'b11, 8'($urandom)}, FW, 2, 8'hC3);
    do_txn({2'b10, 8'($urandom)}, FW, 1, 8'h00);
    do_txn({2'b11, 8'($urandom)}, FW, $urandom_range(1, 10), 8'($urandom));
  endtask

  task automatic test_timeout;
    do_txn({2'b10, 8'($urandom)}, FW, 1, 8'h00);
    do_txn({2'b11, 8'($urandom)}, FW, TO, 8'h00);
    do_txn({2'b11, 8'($urandom)}, FW, 1, 8'h00);
  endtask

  task automatic test_abort;
    do_txn({2'b01, 8'($urandom)}, 5, 1, 8'h00);
    do_txn(10'h1F0, FW, 1, 8'h00);
    do_txn({2'b10, 8'($urandom)}, FW - 1, 1, 8'h00);
    for (int i = 0; i < 3; i++) do_txn(10'($urandom), $urandom_range(1, FW - 1), 1, 8'h00);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 25; i++)
      do_txn({2'($urandom_range(0, 3)), 8'($urandom)},
             $urandom_range(0, 4) == 0 ? $urandom_range(1, FW - 1) : FW,
             $urandom_range(0, 5) == 0 ? TO : $urandom_range(1, 5), 8'($urandom));
  endtask

`ifdef SPI_PARITY_EN
  task automatic test_parity;
    flip_par = 1;
    do_txn(10'h001, FW, 1, 8'h00);
    flip_par = 0;
    do_txn(10'h001, FW, 1, 8'h00);
  endtask
`endif

  initial begin
    test_reset();
    test_write_addr();
    test_read_unarmed();
    test_read();
    test_timeout();
    test_abort();
    test_back_to_back();
`ifdef SPI_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
